// File: rtl/base_and_or_reg.sv
`default_nettype none
// ============================================================================
//  Module   : base_and_or_reg
//  Purpose  : Registered bitwise logic unit. Each rising clk edge captures
//             either aIn & bIn or aIn | bIn, chosen by two one-hot mode
//             strobes. The captured result and a flag naming its operation
//             are the only state in the block.
//  Ports    :
//    clk    in   1      sole clock, rising edge
//    rst_n  in   1      asynchronous active-low reset
//    aIn    in   WIDTH  operand A
//    bIn    in   WIDTH  operand B
//    doAnd  in   1      request AND
//    doOr   in   1      request OR
//    isAnd  out  1      registered, 1 when out holds an AND result
//    out    out  WIDTH  registered result
//  Revision : 1.0 - initial release
// ============================================================================
module base_and_or_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    input  logic             doAnd,
    input  logic             doOr,
    output logic             isAnd,
    output logic [WIDTH-1:0] out
);

    logic             w_sel_and;
    logic             w_sel_or;
    logic [WIDTH-1:0] w_next;

    logic             r_is_and;
    logic [WIDTH-1:0] r_out;

    // Only the two exact one-hot codes select an operation; idle (00) and
    // the conflicting request (11) both fall through to an all-zero result.
    assign w_sel_and = doAnd & ~doOr;
    assign w_sel_or  = ~doAnd & doOr;

    assign w_next = ({WIDTH{w_sel_and}} & (aIn & bIn))
                  | ({WIDTH{w_sel_or}}  & (aIn | bIn));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_is_and <= 1'b0;
        end else begin
            r_out    <= w_next;
            r_is_and <= w_sel_and;
        end
    end

    assign out   = r_out;
    assign isAnd = r_is_and;

endmodule
`default_nettype wire

// File: tb/tb_base_and_or_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_base_and_or_reg
//  Purpose  : Directed self-checking bench for base_and_or_reg (WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_base_and_or_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic       doAnd;
    logic       doOr;
    logic       isAnd;
    logic [3:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    base_and_or_reg #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .aIn   (aIn),
        .bIn   (bIn),
        .doAnd (doAnd),
        .doOr  (doOr),
        .isAnd (isAnd),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, clock once, sample at the next
    // falling edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic da, input logic dor);
        aIn   = a;
        bIn   = b;
        doAnd = da;
        doOr  = dor;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        aIn   = 4'b1111;
        bIn   = 4'b1111;
        doAnd = 1'b1;
        doOr  = 1'b0;
        #1;
        chk("reset_out_immediate", out, 4'b0000);
        chk("reset_isand_immediate", {3'b000, isAnd}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_held", out, 4'b0000);
        chk("reset_isand_held", {3'b000, isAnd}, 4'b0000);
        rst_n = 1'b1;

        step(4'b0101, 4'b0011, 1'b1, 1'b0);
        chk("and_out", out, 4'b0001);
        chk("and_isand", {3'b000, isAnd}, 4'b0001);

        step(4'b0101, 4'b0011, 1'b0, 1'b1);
        chk("or_out", out, 4'b0111);
        chk("or_isand", {3'b000, isAnd}, 4'b0000);

        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        chk("conflict_out", out, 4'b0000);
        chk("conflict_isand", {3'b000, isAnd}, 4'b0000);

        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("and_ones_out", out, 4'b1111);
        chk("and_ones_isand", {3'b000, isAnd}, 4'b0001);

        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        chk("idle_out", out, 4'b0000);
        chk("idle_isand", {3'b000, isAnd}, 4'b0000);

        // Complementary operands exercise every bit lane independently.
        step(4'b1010, 4'b0101, 1'b0, 1'b1);
        chk("or_comp_out", out, 4'b1111);
        step(4'b1010, 4'b0101, 1'b1, 1'b0);
        chk("and_comp_out", out, 4'b0000);
        chk("and_comp_isand", {3'b000, isAnd}, 4'b0001);
        step(4'b1100, 4'b1010, 1'b1, 1'b0);
        chk("and_mix_out", out, 4'b1000);
        step(4'b1100, 4'b1010, 1'b0, 1'b1);
        chk("or_mix_out", out, 4'b1110);

        step(4'b0101, 4'b0011, 1'b0, 1'b1);
        chk("pre_reset_out", out, 4'b0111);

        // Reset pulse between edges clears outputs without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out", out, 4'b0000);
        chk("midreset_isand", {3'b000, isAnd}, 4'b0000);
        aIn   = 4'b1010;
        bIn   = 4'b0110;
        doAnd = 1'b1;
        doOr  = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_out", out, 4'b0010);
        chk("post_reset_isand", {3'b000, isAnd}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
